// File: rtl/dsi_pattern_gen_pkg.sv
// Shared types and helpers for the DSI test-pattern source.
package dsi_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_BARS   = 2'd0,
        MODE_RAMP   = 2'd1,
        MODE_CHECK  = 2'd2,
        MODE_BORDER = 2'd3
    } mode_e;

    localparam int MAX_BPC = 32;

    // Expands one colour bit to a full-scale (all ones) or zero component of bpc bits.
    function automatic logic [MAX_BPC-1:0] comp_scale(input logic on, input int unsigned bpc);
        logic [MAX_BPC-1:0] ones;
        ones = '1;
        return on ? (ones >> (MAX_BPC - bpc)) : '0;
    endfunction

endpackage

// File: rtl/dsi_pattern_gen_if.sv
// Video output bus of the pattern source: raster syncs, coordinates and RGB pixel.
interface dsi_pattern_gen_if #(
    parameter int BPC = 8,
    parameter int CW  = 12
);
    logic           hs;
    logic           vs;
    logic           de;
    logic           frame_start;
    logic [BPC-1:0] pix_r;
    logic [BPC-1:0] pix_g;
    logic [BPC-1:0] pix_b;
    logic [CW-1:0]  x;
    logic [CW-1:0]  y;

    modport master (output hs, vs, de, frame_start, pix_r, pix_g, pix_b, x, y);
    modport slave  (input  hs, vs, de, frame_start, pix_r, pix_g, pix_b, x, y);
endinterface

// File: rtl/dsi_pattern_gen_timing.sv
// Raster timing: h/v counters, registered hs/vs/de/x/y and frame-start strobe.
module dsi_video_timing
    import dsi_pattern_pkg::*;
#(
    parameter int H_ACTIVE = 720,
    parameter int H_FP     = 10,
    parameter int H_SYNC   = 2,
    parameter int H_BP     = 10,
    parameter int V_ACTIVE = 1280,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 10,
    parameter int CW       = 12
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          pix_ce,
    output logic          cur_de,
    output logic [CW-1:0] cur_x,
    output logic [CW-1:0] cur_y,
    output logic          cur_origin,
    output logic          cur_line_end,
    output logic          hs,
    output logic          vs,
    output logic          de,
    output logic          frame_start,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL + 1);
    localparam int VW      = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          de_q, de_d;
    logic          fs_q, fs_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;

    always_comb begin
        cur_de       = (h_q < H_ACT) && (v_q < V_ACT);
        cur_x        = cur_de ? CW'(h_q) : '0;
        cur_y        = cur_de ? CW'(v_q) : '0;
        cur_origin   = (h_q == '0) && (v_q == '0);
        cur_line_end = (h_q == H_LAST);

        h_d  = h_q;
        v_d  = v_q;
        hs_d = hs_q;
        vs_d = vs_q;
        de_d = de_q;
        x_d  = x_q;
        y_d  = y_q;
        // The strobe is a single sys_clk pulse even when pix_ce idles afterwards.
        fs_d = 1'b0;

        if (pix_ce) begin
            hs_d = (h_q >= HS_BEG) && (h_q < HS_END);
            vs_d = (v_q >= VS_BEG) && (v_q < VS_END);
            de_d = cur_de;
            x_d  = cur_x;
            y_d  = cur_y;
            fs_d = cur_origin;
            if (cur_line_end) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            h_q  <= '0;
            v_q  <= '0;
            hs_q <= 1'b0;
            vs_q <= 1'b0;
            de_q <= 1'b0;
            fs_q <= 1'b0;
            x_q  <= '0;
            y_q  <= '0;
        end else begin
            h_q  <= h_d;
            v_q  <= v_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
            de_q <= de_d;
            fs_q <= fs_d;
            x_q  <= x_d;
            y_q  <= y_d;
        end
    end

    assign hs          = hs_q;
    assign vs          = vs_q;
    assign de          = de_q;
    assign frame_start = fs_q;
    assign x           = x_q;
    assign y           = y_q;

endmodule

// File: rtl/dsi_pattern_gen.sv
// Parametrised video test-pattern source: four runtime-selectable patterns over
// configurable raster timing, mode steps only at frame boundaries.
module dsi_pattern_gen
    import dsi_pattern_pkg::*;
#(
    parameter int H_ACTIVE   = 720,
    parameter int H_FP       = 10,
    parameter int H_SYNC     = 2,
    parameter int H_BP       = 10,
    parameter int V_ACTIVE   = 1280,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 10,
    parameter int BPC        = 8,
    parameter int NUM_BARS   = 8,
    parameter int CHECK_LOG2 = 5,
    parameter int CW         = 12,
    parameter int INIT_MODE  = 0
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               pix_ce,
    input  logic               mode_next,
    output logic [1:0]         mode_cur,
    dsi_pattern_gen_if.master  vid
);

    localparam int BAR_W = H_ACTIVE / NUM_BARS;
    localparam int BI    = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;

    localparam logic [BI-1:0] LAST_BAR   = BI'(NUM_BARS - 1);
    localparam logic [CW-1:0] BAR_W_LAST = CW'(BAR_W - 1);
    localparam logic [CW-1:0] X_LAST     = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] Y_LAST     = CW'(V_ACTIVE - 1);
    localparam mode_e         INIT_M     = mode_e'(INIT_MODE[1:0]);

    logic          cur_de;
    logic [CW-1:0] cur_x;
    logic [CW-1:0] cur_y;
    logic          cur_origin;
    logic          cur_line_end;

    dsi_video_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .CW       (CW)
    ) u_timing (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .pix_ce       (pix_ce),
        .cur_de       (cur_de),
        .cur_x        (cur_x),
        .cur_y        (cur_y),
        .cur_origin   (cur_origin),
        .cur_line_end (cur_line_end),
        .hs           (vid.hs),
        .vs           (vid.vs),
        .de           (vid.de),
        .frame_start  (vid.frame_start),
        .x            (vid.x),
        .y            (vid.y)
    );

    logic [CW-1:0]  bar_pos_q, bar_pos_d;
    logic [BI-1:0]  bar_idx_q, bar_idx_d;
    mode_e          mode_q, mode_d;
    logic           pending_q, pending_d;
    logic           pend_eff;
    logic [BPC-1:0] pix_r_q, pix_r_d;
    logic [BPC-1:0] pix_g_q, pix_g_d;
    logic [BPC-1:0] pix_b_q, pix_b_d;
    logic [BPC-1:0] pat_r, pat_g, pat_b;
    logic [2:0]     bar_i;
    logic           border;

    // Bar index tracks the current pixel with an in-bar counter; the last bar
    // absorbs the remainder of H_ACTIVE / NUM_BARS.
    always_comb begin
        bar_pos_d = bar_pos_q;
        bar_idx_d = bar_idx_q;
        if (pix_ce) begin
            if (cur_line_end) begin
                bar_pos_d = '0;
                bar_idx_d = '0;
            end else if (cur_de) begin
                if ((bar_pos_q == BAR_W_LAST) && (bar_idx_q != LAST_BAR)) begin
                    bar_pos_d = '0;
                    bar_idx_d = bar_idx_q + 1'b1;
                end else begin
                    bar_pos_d = bar_pos_q + 1'b1;
                end
            end
        end
    end

    // A request arriving on the boundary cycle itself is consumed by that boundary.
    always_comb begin
        pend_eff  = pending_q | mode_next;
        mode_d    = mode_q;
        pending_d = pend_eff;
        if (pix_ce && cur_origin) begin
            pending_d = 1'b0;
            if (pend_eff) begin
                mode_d = mode_e'(mode_q + 2'd1);
            end
        end
    end

    always_comb begin
        bar_i  = 3'(bar_idx_q);
        border = (cur_x == '0) || (cur_x == X_LAST) || (cur_y == '0) || (cur_y == Y_LAST);
        pat_r  = '0;
        pat_g  = '0;
        pat_b  = '0;
        case (mode_d)
            MODE_BARS: begin
                pat_r = BPC'(comp_scale(~bar_i[1], BPC));
                pat_g = BPC'(comp_scale(~bar_i[2], BPC));
                pat_b = BPC'(comp_scale(~bar_i[0], BPC));
            end
            MODE_RAMP: begin
                pat_r = BPC'(cur_x);
                pat_g = BPC'(cur_x);
                pat_b = BPC'(cur_x);
            end
            MODE_CHECK: begin
                pat_r = BPC'(comp_scale(cur_x[CHECK_LOG2] ^ cur_y[CHECK_LOG2], BPC));
                pat_g = pat_r;
                pat_b = pat_r;
            end
            MODE_BORDER: begin
                pat_r = BPC'(comp_scale(border, BPC));
                pat_g = pat_r;
                pat_b = BPC'(comp_scale(1'b1, BPC));
            end
        endcase

        pix_r_d = pix_r_q;
        pix_g_d = pix_g_q;
        pix_b_d = pix_b_q;
        if (pix_ce) begin
            pix_r_d = cur_de ? pat_r : '0;
            pix_g_d = cur_de ? pat_g : '0;
            pix_b_d = cur_de ? pat_b : '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            bar_pos_q <= '0;
            bar_idx_q <= '0;
            mode_q    <= INIT_M;
            pending_q <= 1'b0;
            pix_r_q   <= '0;
            pix_g_q   <= '0;
            pix_b_q   <= '0;
        end else begin
            bar_pos_q <= bar_pos_d;
            bar_idx_q <= bar_idx_d;
            mode_q    <= mode_d;
            pending_q <= pending_d;
            pix_r_q   <= pix_r_d;
            pix_g_q   <= pix_g_d;
            pix_b_q   <= pix_b_d;
        end
    end

    assign mode_cur  = mode_q;
    assign vid.pix_r = pix_r_q;
    assign vid.pix_g = pix_g_q;
    assign vid.pix_b = pix_b_q;

endmodule

// File: tb/tb_dsi_pattern_gen.sv
// Self-checking bench for dsi_pattern_gen on a 22x11 raster against a frame-level model.
module tb_dsi_pattern_gen;

    localparam int HA = 16;
    localparam int HT = 22;
    localparam int VA = 8;
    localparam int VT = 11;
    localparam int FRAME = HT * VT;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n;
    logic       pix_ce;
    logic       mode_next;
    logic [1:0] mode_cur;
    logic [1:0] mode_cur3;

    int n_checks = 0;
    int n_pass   = 0;
    int lin      = 0;

    always #5 sys_clk = ~sys_clk;

    dsi_pattern_gen_if #(.BPC(8), .CW(12)) vif ();
    dsi_pattern_gen_if #(.BPC(8), .CW(12)) vif3 ();

    dsi_pattern_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .BPC(8), .NUM_BARS(8), .CHECK_LOG2(1), .CW(12), .INIT_MODE(0)
    ) u_dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .pix_ce    (pix_ce),
        .mode_next (mode_next),
        .mode_cur  (mode_cur),
        .vid       (vif)
    );

    dsi_pattern_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .BPC(8), .NUM_BARS(3), .CHECK_LOG2(1), .CW(12), .INIT_MODE(0)
    ) u_dut3 (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .pix_ce    (pix_ce),
        .mode_next (mode_next),
        .mode_cur  (mode_cur3),
        .vid       (vif3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [23:0] bar_colour(input int i);
        case (i)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [23:0] model_pixel(input int mode, input int x, input int y,
                                                input bit de, input int nbars);
        int idx;
        logic [7:0] g;
        if (!de) return 24'h0;
        case (mode)
            0: begin
                idx = x / (HA / nbars);
                if (idx > nbars - 1) idx = nbars - 1;
                return bar_colour(idx % 8);
            end
            1: begin
                g = 8'(x);
                return {g, g, g};
            end
            2: return ((((x / 2) ^ (y / 2)) % 2) == 1) ? 24'hFFFFFF : 24'h000000;
            default: return (x == 0 || x == HA - 1 || y == 0 || y == VA - 1) ? 24'hFFFFFF : 24'h0000FF;
        endcase
    endfunction

    // Frame-level model: position, mode and pending request, plus expected outputs.
    int          m_h, m_v, m_mode;
    bit          m_pend, m_valid = 1'b0, pend_e;
    bit          e_hs, e_vs, e_de, e_fs;
    int          e_x, e_y;
    logic [23:0] e_pix, e_pix3;

    always @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            m_h = 0; m_v = 0; m_mode = 0; m_pend = 1'b0; m_valid = 1'b1;
            e_hs = 0; e_vs = 0; e_de = 0; e_fs = 0; e_x = 0; e_y = 0;
            e_pix = 24'h0; e_pix3 = 24'h0;
        end else if (m_valid) begin
            pend_e = m_pend || mode_next;
            if (pix_ce) begin
                if (m_h == 0 && m_v == 0) begin
                    if (pend_e) m_mode = (m_mode + 1) % 4;
                    m_pend = 1'b0;
                end else begin
                    m_pend = pend_e;
                end
                e_de   = (m_h < HA) && (m_v < VA);
                e_hs   = (m_h >= HA + 2) && (m_h < HA + 4);
                e_vs   = (m_v == VA + 1);
                e_fs   = (m_h == 0) && (m_v == 0);
                e_x    = e_de ? m_h : 0;
                e_y    = e_de ? m_v : 0;
                e_pix  = model_pixel(m_mode, e_x, e_y, e_de, 8);
                e_pix3 = model_pixel(m_mode, e_x, e_y, e_de, 3);
                m_h++;
                if (m_h == HT) begin
                    m_h = 0;
                    m_v = (m_v + 1) % VT;
                end
            end else begin
                m_pend = pend_e;
                e_fs   = 1'b0;
            end
        end
    end

    always @(negedge sys_clk) begin
        if (m_valid) begin
            chk("hs", vif.hs, e_hs);
            chk("vs", vif.vs, e_vs);
            chk("de", vif.de, e_de);
            chk("frame_start", vif.frame_start, e_fs);
            chk("x", vif.x, e_x);
            chk("y", vif.y, e_y);
            chk("pix", {vif.pix_r, vif.pix_g, vif.pix_b}, e_pix);
            chk("mode_cur", mode_cur, m_mode);
            chk("pix_bars3", {vif3.pix_r, vif3.pix_g, vif3.pix_b}, e_pix3);
            chk("mode_cur_bars3", mode_cur3, m_mode);
        end
    end

    task automatic applyStimulus(input bit ce, input bit mn);
        pix_ce    = ce;
        mode_next = mn;
        if (!sys_rst_n) lin = 0;
        else if (ce) lin++;
        @(negedge sys_clk);
    endtask

    task automatic gotoPos(input int h, input int v);
        int g = 0;
        while (!(lin > 0 && ((lin - 1) % FRAME) == v * HT + h) && g < 2 * FRAME) begin
            applyStimulus(1'b1, 1'b0);
            g++;
        end
        chk("goto_reached", g < 2 * FRAME, 1);
    endtask

    task automatic checkOutput(input string name, input logic [23:0] pix);
        chk(name, {vif.pix_r, vif.pix_g, vif.pix_b}, pix);
    endtask

    task automatic measurePeriod(input bit alt, output int period);
        int g = 0;
        period = -1;
        while (vif.frame_start !== 1'b1 && g < 600) begin
            applyStimulus(1'b1, 1'b0);
            g++;
        end
        for (int n = 1; n <= 1000; n++) begin
            applyStimulus(alt ? ((n % 2) == 0) : 1'b1, 1'b0);
            if (vif.frame_start === 1'b1) begin
                period = n;
                break;
            end
        end
    endtask

    initial begin
        int period;
        sys_rst_n = 1'b0;
        pix_ce    = 1'b0;
        mode_next = 1'b0;
        @(negedge sys_clk);
        repeat (3) applyStimulus(1'b1, 1'b0);
        chk("reset_de", vif.de, 0);
        chk("reset_fs", vif.frame_start, 0);
        chk("reset_mode", mode_cur, 0);
        checkOutput("reset_pix", 24'h0);

        $display("[TB] colour bars and raster timing");
        sys_rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0);
        chk("first_fs", vif.frame_start, 1);
        checkOutput("bar_x0", 24'hFFFFFF);
        gotoPos(2, 0);  checkOutput("bar_x2", 24'hFFFF00);
        gotoPos(9, 0);  chk("bars3_x9", {vif3.pix_r, vif3.pix_g, vif3.pix_b}, 24'hFFFF00);
        gotoPos(10, 0); chk("bars3_x10", {vif3.pix_r, vif3.pix_g, vif3.pix_b}, 24'h00FFFF);
        gotoPos(15, 0); checkOutput("bar_x15", 24'h000000);
        chk("bars3_x15", {vif3.pix_r, vif3.pix_g, vif3.pix_b}, 24'h00FFFF);
        gotoPos(18, 0); chk("hs_h18", vif.hs, 1); chk("de_h18", vif.de, 0);
        gotoPos(20, 0); chk("hs_h20", vif.hs, 0);
        gotoPos(0, 9);  chk("vs_v9", vif.vs, 1);
        measurePeriod(1'b0, period);
        chk("frame_period_cont", period, 242);

        $display("[TB] mid-frame requests collapse to one step");
        gotoPos(4, 2);  applyStimulus(1'b1, 1'b1);
        gotoPos(8, 3);  applyStimulus(1'b1, 1'b1);
        gotoPos(1, 5);  applyStimulus(1'b1, 1'b1);
        gotoPos(21, 10); chk("mode_hold_midframe", mode_cur, 0);
        applyStimulus(1'b1, 1'b0);
        chk("mode_step1", mode_cur, 1);
        gotoPos(5, 0);  checkOutput("ramp_x5", 24'h050505);

        $display("[TB] boundary-cycle requests");
        gotoPos(21, 10); applyStimulus(1'b1, 1'b1);
        chk("fs_boundary", vif.frame_start, 1);
        chk("mode_step2", mode_cur, 2);
        checkOutput("check_0_0", 24'h000000);
        gotoPos(2, 0);  checkOutput("check_2_0", 24'hFFFFFF);
        gotoPos(2, 2);  checkOutput("check_2_2", 24'h000000);
        gotoPos(21, 10); applyStimulus(1'b1, 1'b1);
        chk("mode_step3", mode_cur, 3);
        gotoPos(0, 3);  checkOutput("border_0_3", 24'hFFFFFF);
        gotoPos(5, 3);  checkOutput("border_5_3", 24'h0000FF);
        gotoPos(15, 7); checkOutput("border_15_7", 24'hFFFFFF);
        gotoPos(21, 10); applyStimulus(1'b1, 1'b1);
        chk("mode_wrap", mode_cur, 0);

        $display("[TB] alternating pixel enable");
        measurePeriod(1'b1, period);
        chk("frame_period_alt", period, 484);

        $display("[TB] mid-frame reset");
        gotoPos(21, 10); applyStimulus(1'b1, 1'b1);
        chk("mode_pre_reset", mode_cur, 1);
        gotoPos(2, 1);  applyStimulus(1'b1, 1'b1);
        gotoPos(3, 4);
        sys_rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0);
        chk("rst_de", vif.de, 0);
        chk("rst_x", vif.x, 0);
        chk("rst_mode", mode_cur, 0);
        checkOutput("rst_pix", 24'h0);
        sys_rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0);
        chk("rst_restart_fs", vif.frame_start, 1);
        chk("rst_restart_y", vif.y, 0);
        checkOutput("rst_restart_pix", 24'hFFFFFF);
        gotoPos(21, 10); applyStimulus(1'b1, 1'b0);
        chk("rst_cleared_pending", mode_cur, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
